// File: rtl/crc_hash_pkg.sv
// crc_hash_pkg: CRC width, default polynomials, FSM state type and the
// MSB-first byte step shared by crc_stream_hash and crc_hash_step.
package crc_hash_pkg;

    localparam int CRC_W = 32;

    localparam logic [CRC_W-1:0] POLY_CRC32  = 32'h04C11DB7;
    localparam logic [CRC_W-1:0] POLY_CRC32C = 32'h1EDC6F41;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    // Non-reflected, no final XOR: data bit 7 enters first.
    function automatic logic [CRC_W-1:0] crc_byte(
        input logic [CRC_W-1:0] crc,
        input logic [7:0]       d,
        input logic [CRC_W-1:0] poly
    );
        logic [CRC_W-1:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[CRC_W-1] ^ d[i]) c = {c[CRC_W-2:0], 1'b0} ^ poly;
            else                   c = {c[CRC_W-2:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_hash_step.sv
// crc_hash_step: combinational one-beat CRC update for one polynomial;
// only the lowest 'count' bytes of the beat are folded in.
module crc_hash_step
    import crc_hash_pkg::*;
#(
    parameter int               BYTES = 4,
    parameter logic [CRC_W-1:0] POLY  = POLY_CRC32C,
    localparam int              CNT_W = $clog2(BYTES + 1)
) (
    input  logic [CRC_W-1:0]     crc_in,
    input  logic [BYTES-1:0][7:0] data,
    input  logic [CNT_W-1:0]     count,
    output logic [CRC_W-1:0]     crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < BYTES; i++) begin
            if (i < int'(count)) crc_out = crc_byte(crc_out, data[i], POLY);
        end
    end

endmodule

// File: rtl/crc_stream_hash.sv
// crc_stream_hash: framed byte-stream hasher with NUM_HASH parallel CRC32s.
// Define CRC_STREAM_HASH_IN_REG_EN to add a registered input stage.
module crc_stream_hash
    import crc_hash_pkg::*;
#(
    parameter int                             BYTES_PER_BEAT = 4,
    parameter int                             NUM_HASH       = 2,
    parameter logic [NUM_HASH-1:0][CRC_W-1:0] POLYS          = {POLY_CRC32, POLY_CRC32C},
    parameter logic [CRC_W-1:0]               INIT           = 32'hFFFFFFFF,
    localparam int EMPTY_W = (BYTES_PER_BEAT > 1) ? $clog2(BYTES_PER_BEAT) : 1,
    localparam int CNT_W   = $clog2(BYTES_PER_BEAT + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic [BYTES_PER_BEAT-1:0][7:0]    data_i,
    input  logic                              valid_i,
    input  logic                              sop_i,
    input  logic                              eop_i,
    input  logic [EMPTY_W-1:0]                empty_i,
    output logic                              ready_o,
    output logic [NUM_HASH-1:0][CRC_W-1:0]    crc_o,
    output logic [15:0]                       len_o,
    output logic                              crc_valid_o,
    input  logic                              crc_ready_i,
    output logic                              err_o
);

    logic [BYTES_PER_BEAT-1:0][7:0] b_data;
    logic                           b_valid;
    logic                           b_sop;
    logic                           b_eop;
    logic [EMPTY_W-1:0]             b_empty;
    logic                           fsm_ready;

`ifdef CRC_STREAM_HASH_IN_REG_EN
    logic [BYTES_PER_BEAT-1:0][7:0] r_data;
    logic                           r_valid;
    logic                           r_sop;
    logic                           r_eop;
    logic [EMPTY_W-1:0]             r_empty;

    // Stage refills whenever it is empty or its beat moves on this cycle.
    assign ready_o = !r_valid || fsm_ready;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_empty <= '0;
        end else if (ready_o) begin
            r_data  <= data_i;
            r_valid <= valid_i;
            r_sop   <= sop_i;
            r_eop   <= eop_i;
            r_empty <= empty_i;
        end
    end

    assign b_data  = r_data;
    assign b_valid = r_valid;
    assign b_sop   = r_sop;
    assign b_eop   = r_eop;
    assign b_empty = r_empty;
`else
    assign ready_o = fsm_ready;
    assign b_data  = data_i;
    assign b_valid = valid_i;
    assign b_sop   = sop_i;
    assign b_eop   = eop_i;
    assign b_empty = empty_i;
`endif

    state_t                         state_q, state_d;
    logic [NUM_HASH-1:0][CRC_W-1:0] crc_q, crc_d, crc_step;
    logic [15:0]                    len_q, len_d, len_next;
    logic                           err_q, err_d;
    logic                           fire;
    logic                           restart;
    logic [CNT_W-1:0]               count;
    logic [16:0]                    len_sum;

    assign fsm_ready = (state_q != HOLD);
    assign fire      = b_valid && fsm_ready;
    assign restart   = (state_q == IDLE) || b_sop;

    always_comb begin
        count = CNT_W'(BYTES_PER_BEAT);
        if (b_eop) begin
            if (int'(b_empty) < BYTES_PER_BEAT)
                count = CNT_W'(BYTES_PER_BEAT - int'(b_empty));
            else
                count = '0;
        end
    end

    for (genvar h = 0; h < NUM_HASH; h++) begin : g_eng
        logic [CRC_W-1:0] base;
        assign base = restart ? INIT : crc_q[h];
        crc_hash_step #(
            .BYTES (BYTES_PER_BEAT),
            .POLY  (POLYS[h])
        ) u_step (
            .crc_in  (base),
            .data    (b_data),
            .count   (count),
            .crc_out (crc_step[h])
        );
    end

    assign len_sum  = {1'b0, (restart ? 16'd0 : len_q)} + 17'(count);
    assign len_next = len_sum[16] ? 16'hFFFF : len_sum[15:0];

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        len_d   = len_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fire) begin
                    if (b_sop) begin
                        crc_d   = crc_step;
                        len_d   = len_next;
                        state_d = b_eop ? HOLD : ACCUM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (fire) begin
                    crc_d = crc_step;
                    len_d = len_next;
                    err_d = b_sop;
                    if (b_eop) state_d = HOLD;
                end
            end
            HOLD: begin
                if (crc_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            crc_q   <= {NUM_HASH{INIT}};
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    assign crc_o       = crc_q;
    assign len_o       = len_q;
    assign crc_valid_o = (state_q == HOLD);
    assign err_o       = err_q;

endmodule
